// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield controller.
package tug_pkg;

   typedef enum logic [1:0] {
      PLAY,
      ROUND_WON,
      MATCH_OVER
   } tug_state_t;

   typedef enum logic [1:0] {
      SIDE_NONE = 2'b00,
      SIDE_L    = 2'b10,
      SIDE_R    = 2'b01
   } tug_side_t;

endpackage

// File: rtl/tug_rope_field_if.sv
// Player inputs and display outputs of the tug-of-war playfield.
// master: button conditioning / bench side; slave: tug_rope_field.
interface tug_rope_field_if #(
   parameter int NUM_LIGHTS = 9,
   parameter int SCORE_W    = 3
) ();
   import tug_pkg::*;

   logic                  l_press;
   logic                  r_press;
   logic                  play_again;
   logic [NUM_LIGHTS-1:0] lights;
   logic [SCORE_W-1:0]    score_l;
   logic [SCORE_W-1:0]    score_r;
   tug_side_t             round_winner;
   logic                  match_over;

   modport master (
      output l_press, r_press, play_again,
      input  lights, score_l, score_r, round_winner, match_over
   );

   modport slave (
      input  l_press, r_press, play_again,
      output lights, score_l, score_r, round_winner, match_over
   );
endinterface

// File: rtl/tug_score_counter.sv
// Saturating round-win counter with a match-target compare.
// at_target is high when the increment applied this cycle lands on MATCH_SCORE.
module tug_score_counter #(
   parameter int SCORE_W     = 3,
   parameter int MATCH_SCORE = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               inc,
   output logic [SCORE_W-1:0] score,
   output logic               at_target
);
   localparam logic [SCORE_W-1:0] MAXV   = '1;
   localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(MATCH_SCORE);

   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] score_nxt;

   // Next score: increment unless already saturated.
   always_comb begin
      score_nxt = score_q;
      if (inc && (score_q != MAXV)) score_nxt = score_q + 1'b1;
      at_target = inc && (score_nxt == TARGET);
   end

   // Score register; reset and clr both return to zero.
   always_ff @(posedge clk) begin
      if (reset || clr) score_q <= '0;
      else              score_q <= score_nxt;
   end

   assign score = score_q;
endmodule

// File: rtl/tug_rope_field.sv
// Tug-of-war playfield: position register driving a one-hot light bar,
// round-win detection, per-player scores and match-over detection.
// Optional macro TUG_WIN_FLASH_EN: flashes the winner's end light with a
// half-period of FLASH_CYCLES clocks; undefined gives a steady end light.
module tug_rope_field
   import tug_pkg::*;
#(
   parameter int NUM_LIGHTS   = 9,
   parameter int MATCH_SCORE  = 3,
   parameter int SCORE_W      = 3,
   parameter int FLASH_CYCLES = 25000000
) (
   input logic               clk,
   input logic               reset,
   tug_rope_field_if.slave   bus
);
   localparam int              PW   = $clog2(NUM_LIGHTS);
   localparam logic [PW-1:0]   CTR  = PW'((NUM_LIGHTS - 1) / 2);
   localparam logic [PW-1:0]   LAST = PW'(NUM_LIGHTS - 1);

   if ((NUM_LIGHTS < 3) || ((NUM_LIGHTS % 2) == 0)) begin : g_bad_lights
      $error("NUM_LIGHTS must be odd and >= 3");
   end
   if ((MATCH_SCORE < 1) || (MATCH_SCORE > ((1 << SCORE_W) - 1))) begin : g_bad_score
      $error("MATCH_SCORE out of range for SCORE_W");
   end
   if (FLASH_CYCLES < 1) begin : g_bad_flash
      $error("FLASH_CYCLES must be >= 1");
   end

   tug_state_t         state;
   tug_side_t          winner;
   logic [PW-1:0]      pos;
   logic               match_over_q;
   logic               mv_l, mv_r;
   logic               win_l, win_r;
   logic               hit_l, hit_r;
   logic               score_clr;
   logic               flash_on;
   logic [SCORE_W-1:0] score_l_w, score_r_w;

   assign mv_l = bus.l_press & ~bus.r_press;
   assign mv_r = bus.r_press & ~bus.l_press;

   // A pull past the end of the bar is a round win for the puller.
   assign win_l     = (state == PLAY) & ~bus.play_again & mv_l & (pos == LAST);
   assign win_r     = (state == PLAY) & ~bus.play_again & mv_r & (pos == '0);
   assign score_clr = bus.play_again & (state == MATCH_OVER);

   tug_score_counter #(.SCORE_W(SCORE_W), .MATCH_SCORE(MATCH_SCORE)) u_score_l (
      .clk(clk), .reset(reset), .clr(score_clr), .inc(win_l),
      .score(score_l_w), .at_target(hit_l)
   );

   tug_score_counter #(.SCORE_W(SCORE_W), .MATCH_SCORE(MATCH_SCORE)) u_score_r (
      .clk(clk), .reset(reset), .clr(score_clr), .inc(win_r),
      .score(score_r_w), .at_target(hit_r)
   );

   // Round FSM with position, winner and match-over registers.
   always_ff @(posedge clk) begin
      if (reset || bus.play_again) begin
         state        <= PLAY;
         pos          <= CTR;
         winner       <= SIDE_NONE;
         match_over_q <= 1'b0;
      end else begin
         case (state)
            PLAY: begin
               if (mv_l) begin
                  if (pos < LAST) begin
                     pos <= pos + 1'b1;
                  end else begin
                     winner <= SIDE_L;
                     if (hit_l) begin
                        state        <= MATCH_OVER;
                        match_over_q <= 1'b1;
                     end else begin
                        state <= ROUND_WON;
                     end
                  end
               end else if (mv_r) begin
                  if (pos > '0) begin
                     pos <= pos - 1'b1;
                  end else begin
                     winner <= SIDE_R;
                     if (hit_r) begin
                        state        <= MATCH_OVER;
                        match_over_q <= 1'b1;
                     end else begin
                        state <= ROUND_WON;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TUG_WIN_FLASH_EN
   localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

   logic [FW-1:0] flash_cnt;

   // Flash phase: held at start (on, count 0) while playing so each win enters in the on phase.
   always_ff @(posedge clk) begin
      if (reset || (state == PLAY)) begin
         flash_cnt <= '0;
         flash_on  <= 1'b1;
      end else if (flash_cnt == FLASH_LAST) begin
         flash_cnt <= '0;
         flash_on  <= ~flash_on;
      end else begin
         flash_cnt <= flash_cnt + 1'b1;
      end
   end
`else
   assign flash_on = 1'b1;
`endif

   // Light bar: one-hot position while playing, winner's end light otherwise.
   always_comb begin
      bus.lights = '0;
      if (state == PLAY) begin
         bus.lights = NUM_LIGHTS'(1) << pos;
      end else if (winner == SIDE_L) begin
         bus.lights[NUM_LIGHTS-1] = flash_on;
      end else begin
         bus.lights[0] = flash_on;
      end
   end

   assign bus.score_l      = score_l_w;
   assign bus.score_r      = score_r_w;
   assign bus.round_winner = winner;
   assign bus.match_over   = match_over_q;
endmodule

// File: tb/tb_tug_rope_field.sv
// Directed scoreboard bench for tug_rope_field (NUM_LIGHTS=9, MATCH_SCORE=3,
// FLASH_CYCLES=4). Flash expectations follow TUG_WIN_FLASH_EN if defined.
module tb_tug_rope_field;
   import tug_pkg::*;

   localparam logic [8:0] CTRL = 9'b000010000;

   logic clk = 1'b0;
   logic reset;

   tug_rope_field_if #(.NUM_LIGHTS(9), .SCORE_W(3)) bus ();

   tug_rope_field #(
      .NUM_LIGHTS(9), .MATCH_SCORE(3), .SCORE_W(3), .FLASH_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] lights;
      logic [2:0] sl;
      logic [2:0] sr;
      logic [1:0] w;
      logic       mo;
      int         id;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_push = 0;

   // Winner's end light k edges after entering a won state.
   function automatic logic [8:0] endl(input logic left, input int k);
      logic on;
`ifdef TUG_WIN_FLASH_EN
      on = (((k / 4) % 2) == 0);
`else
      on = 1'b1 | (k < 0);
`endif
      return left ? {on, 8'b0} : {8'b0, on};
   endfunction

   task automatic step(input logic l, input logic r, input logic pa, input logic rst,
                       input logic [8:0] el, input logic [2:0] esl, input logic [2:0] esr,
                       input logic [1:0] ew, input logic emo);
      exp_t e;
      @(negedge clk);
      bus.l_press    = l;
      bus.r_press    = r;
      bus.play_again = pa;
      reset          = rst;
      e.lights = el; e.sl = esl; e.sr = esr; e.w = ew; e.mo = emo; e.id = n_push;
      n_push++;
      exp_q.push_back(e);
   endtask

   // Monitor: every edge is an output; compare against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.lights !== e.lights || bus.score_l !== e.sl || bus.score_r !== e.sr ||
                bus.round_winner !== e.w || bus.match_over !== e.mo) begin
               n_err++;
               $display("FAIL vec%0d: got lights=%b sl=%0d sr=%0d w=%b mo=%b, want lights=%b sl=%0d sr=%0d w=%b mo=%b",
                        e.id, bus.lights, bus.score_l, bus.score_r, bus.round_winner, bus.match_over,
                        e.lights, e.sl, e.sr, e.w, e.mo);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.l_press = 1'b0;
      bus.r_press = 1'b0;
      bus.play_again = 1'b0;

      // Reset state
      step(0, 0, 0, 1, CTRL, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, CTRL, 0, 0, 2'b00, 0);

      // Left pulls, then simultaneous presses hold
      step(1, 0, 0, 0, 9'b000100000, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 9'b001000000, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 9'b010000000, 0, 0, 2'b00, 0);
      step(1, 1, 0, 0, 9'b010000000, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, 9'b010000000, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 9'b100000000, 0, 0, 2'b00, 0);

      // Left wins round from the end; presses ignored; flash/steady window
      step(1, 0, 0, 0, endl(1, 0), 1, 0, 2'b10, 0);
      for (int k = 1; k <= 3; k++) step(0, 1, 0, 0, endl(1, k), 1, 0, 2'b10, 0);
      for (int k = 4; k <= 11; k++) step(0, 0, 0, 0, endl(1, k), 1, 0, 2'b10, 0);
      step(0, 0, 1, 0, CTRL, 1, 0, 2'b00, 0);
      step(0, 0, 0, 0, CTRL, 1, 0, 2'b00, 0);

      // Right wins three rounds -> match over
      for (int rd = 1; rd <= 3; rd++) begin
         for (int p = 3; p >= 0; p--) step(0, 1, 0, 0, 9'(1 << p), 1, 3'(rd - 1), 2'b00, 0);
         step(0, 1, 0, 0, endl(0, 0), 1, 3'(rd), 2'b01, rd == 3);
         step(0, 1, 0, 0, endl(0, 1), 1, 3'(rd), 2'b01, rd == 3);
         step(1, 0, 0, 0, endl(0, 2), 1, 3'(rd), 2'b01, rd == 3);
         if (rd < 3) step(0, 0, 1, 0, CTRL, 1, 3'(rd), 2'b00, 0);
      end
      step(0, 0, 1, 0, CTRL, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, CTRL, 0, 0, 2'b00, 0);

      // play_again held with concurrent pulls keeps the centre
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, CTRL, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 9'b000100000, 0, 0, 2'b00, 0);
      step(1, 0, 1, 0, CTRL, 0, 0, 2'b00, 0);
      step(0, 1, 0, 0, 9'b000001000, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, CTRL, 0, 0, 2'b00, 0);
      for (int p = 5; p <= 8; p++) step(1, 0, 0, 0, 9'(1 << p), 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, endl(1, 0), 1, 0, 2'b10, 0);

      // Reset during ROUND_WON
      step(0, 0, 0, 1, CTRL, 0, 0, 2'b00, 0);
      step(0, 0, 0, 0, CTRL, 0, 0, 2'b00, 0);
      step(1, 0, 0, 0, 9'b000100000, 0, 0, 2'b00, 0);

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      if (n_vec != n_push) begin
         n_err++;
         $display("FAIL count: got %0d compared, want %0d", n_vec, n_push);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
